// File: rtl/bin_to_decimal.sv
// bin_to_decimal
//   Converts a 7-bit unsigned binary score into two registered BCD digits
//   (tens, ones) for the 7-segment digit drivers. Inputs of 100 and above
//   saturate to 99. The latency is one clock and a new value is accepted every cycle.
//
// Ports
//   clk_i   in   1  system clock, rising edge
//   rst_i   in   1  asynchronous, active-high reset; clears both digits
//   bin_i   in   7  unsigned binary value (0..127)
//   tens_o  out  4  registered BCD tens digit (0..9)
//   ones_o  out  4  registered BCD ones digit (0..9)

module bin_to_decimal (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  // Double-dabble pipeline, purely combinational. bcd[k] holds the
  // {tens, ones} nibbles after k input bits have been shifted in, MSB first.
  logic [7:0] bcd [0:7];
  // ovf[k] is set once the partial value has reached 100 or more.
  logic [7:0] ovf;

  assign bcd[0] = 8'd0;
  assign ovf[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_stage
      logic [3:0] tens_adj;
      logic [3:0] ones_adj;

      // A nibble of 5 or more gets +3 so the following doubling carries
      // correctly into the next decimal digit.
      assign tens_adj = (bcd[gi][7:4] >= 4'd5) ? bcd[gi][7:4] + 4'd3 : bcd[gi][7:4];
      assign ones_adj = (bcd[gi][3:0] >= 4'd5) ? bcd[gi][3:0] + 4'd3 : bcd[gi][3:0];

      // Shift in the next input bit. The tens MSB shifted out here would be
      // the hundreds digit. It is only set when the partial value crosses 100,
      // so it becomes the saturation flag and is not carried as a digit.
      assign bcd[gi+1] = {tens_adj[2:0], ones_adj, bin_i[6-gi]};
      assign ovf[gi+1] = ovf[gi] | tens_adj[3];
    end
  endgenerate

  logic [3:0] tens_d;
  logic [3:0] ones_d;
  logic [3:0] tens_q;
  logic [3:0] ones_q;

  always_comb begin
    tens_d = bcd[7][7:4];
    ones_d = bcd[7][3:0];
    if (ovf[7]) begin
      tens_d = 4'd9;
      ones_d = 4'd9;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens_o = tens_q;
  assign ones_o = ones_q;

endmodule

// File: tb/tb_bin_to_decimal.sv
// tb_bin_to_decimal
//   Directed, self-checking bench for bin_to_decimal.

module tb_bin_to_decimal;

  logic       clk;
  logic       rst;
  logic [6:0] bin;
  logic [3:0] tens;
  logic [3:0] ones;

  int checks = 0;
  int errors = 0;

  bin_to_decimal dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bin_i  (bin),
    .tens_o (tens),
    .ones_o (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_digits(input string tag, input logic [3:0] exp_t, input logic [3:0] exp_o);
    check({tag, "_tens"}, {4'd0, tens}, {4'd0, exp_t});
    check({tag, "_ones"}, {4'd0, ones}, {4'd0, exp_o});
    $display("step %s bin=%0d tens=%0d ones=%0d", tag, bin, tens, ones);
  endtask

  // Drive a value, let one rising edge capture it, and sample 1 ns later.
  task automatic apply(input logic [6:0] v);
    bin = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int m;
    rst = 1'b1;
    bin = 7'd0;
    #1;
    check_digits("reset_t0", 4'd0, 4'd0);
    @(posedge clk); #1;
    check_digits("reset_c1", 4'd0, 4'd0);
    @(posedge clk); #1;
    check_digits("reset_c2", 4'd0, 4'd0);

    rst = 1'b0;
    apply(7'd0);  check_digits("bin0", 4'd0, 4'd0);
    apply(7'd5);  check_digits("bin5", 4'd0, 4'd5);
    apply(7'd15); check_digits("bin15", 4'd1, 4'd5);
    apply(7'd42); check_digits("bin42", 4'd4, 4'd2);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    check_digits("async_rst", 4'd0, 4'd0);
    apply(7'd99); check_digits("rst_hold99", 4'd0, 4'd0);

    rst = 1'b0;
    apply(7'd73); check_digits("release73", 4'd7, 4'd3);
    apply(7'd73); check_digits("stable73", 4'd7, 4'd3);

    apply(7'd99);  check_digits("bin99", 4'd9, 4'd9);
    apply(7'd100); check_digits("bin100", 4'd9, 4'd9);
    apply(7'd127); check_digits("bin127", 4'd9, 4'd9);
    apply(7'd60);  check_digits("bin60", 4'd6, 4'd0);
    apply(7'd19);  check_digits("bin19", 4'd1, 4'd9);

    for (int v = 0; v < 128; v++) begin
      apply(v[6:0]);
      m = (v > 99) ? 99 : v;
      check("sweep_tens", {4'd0, tens}, 8'(m / 10));
      check("sweep_ones", {4'd0, ones}, 8'(m % 10));
      check("sweep_value", 8'(10 * tens + ones), 8'(m));
      check("sweep_range", {7'd0, (tens <= 4'd9) && (ones <= 4'd9)}, 8'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
